// File: rtl/cdf_accumulate.sv
// CDF accumulator: running sum of histogram bins, each tagged CDF word written back to memory.
// Latency: one cycle from bin sample to write strobe; done/cdf_total follow the state register.
// Backpressure: none; accepts one bin per cycle, bins beyond NUM_BINS are dropped (optional CDF_MIN_TRACK_EN).

module cdf_accumulate #(
    parameter int          DATA_W   = 20,
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] TAG      = 16'hAAAA,
    parameter int          NUM_BINS = 256
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    acc_in,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    store_addr_in,
    input  logic                 done_in,
    output logic [DATA_W+15:0]   write_bus,
    output logic [ADDR_W-1:0]    write_addr,
    output logic                 write_en,
    output logic [DATA_W-1:0]    cdf_total,
    output logic                 overflow,
    output logic [DATA_W-1:0]    cdf_min,
    output logic                 done
);

    localparam int CNT_W = $clog2(NUM_BINS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_sum;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic [DATA_W+15:0]  r_write_bus;
    logic [ADDR_W-1:0]   r_write_addr;
    logic                r_write_en;

    logic [DATA_W:0]     w_sum_wide;
    logic                w_carry;
    logic [DATA_W-1:0]   w_sum_n;
    logic                w_write;
    logic                w_clear;

    // Saturating add: the carry bit pins the sum at all-ones and flags overflow.
    assign w_sum_wide = {1'b0, r_sum} + {1'b0, acc_in};
    assign w_carry    = w_sum_wide[DATA_W];
    assign w_sum_n    = w_carry ? {DATA_W{1'b1}} : w_sum_wide[DATA_W-1:0];

    // A bin is taken only while accumulating, with data valid and room left in the pass.
    assign w_write = (r_state == S_ACCUM) && start_in && (r_count < CNT_W'(NUM_BINS));

    // Dropping start (abort) or sitting in IDLE returns everything to its cleared value.
    assign w_clear = !start || (r_state == S_IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start low forces IDLE from anywhere.
    always_comb begin
        w_next_state = r_state;
        if (!start) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_ACCUM;
                S_ACCUM: if (done_in) w_next_state = S_DONE;
                S_DONE:  w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Accumulator, bin counter and write port; a final bin arriving with done_in is still written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum        <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_write_bus  <= '0;
            r_write_addr <= '0;
            r_write_en   <= 1'b0;
        end else if (w_clear) begin
            r_sum        <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_write_bus  <= '0;
            r_write_addr <= '0;
            r_write_en   <= 1'b0;
        end else if (w_write) begin
            r_sum        <= w_sum_n;
            r_count      <= r_count + 1'b1;
            r_overflow   <= r_overflow | w_carry;
            r_write_bus  <= {TAG, w_sum_n};
            r_write_addr <= store_addr_in;
            r_write_en   <= 1'b1;
        end else begin
            r_write_en   <= 1'b0;
        end
    end

`ifdef CDF_MIN_TRACK_EN
    logic [DATA_W-1:0] r_cdf_min;

    // First nonzero CDF word of the pass; the sum never decreases, so a nonzero latch marks "captured".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cdf_min <= '0;
        end else if (w_clear) begin
            r_cdf_min <= '0;
        end else if (w_write && (r_cdf_min == '0) && (w_sum_n != '0)) begin
            r_cdf_min <= w_sum_n;
        end
    end

    assign cdf_min = r_cdf_min;
`else
    assign cdf_min = '0;
`endif

    assign write_bus  = r_write_bus;
    assign write_addr = r_write_addr;
    assign write_en   = r_write_en;
    assign overflow   = r_overflow;
    assign done       = (r_state == S_DONE);
    assign cdf_total  = (r_state == S_DONE) ? r_sum : '0;

endmodule

// File: tb/tb_cdf_accumulate.sv
// Directed bench for cdf_accumulate: full pass, saturation, bin limit, abort/restart, min tracking, reset.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point, reflecting that edge.
// No backpressure to model; every wait is a fixed number of cycles.

module tb_cdf_accumulate;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 16;

    logic                clock;
    logic                reset_n;
    logic                start;
    logic [DATA_W-1:0]   acc_in;
    logic                start_in;
    logic [ADDR_W-1:0]   store_addr_in;
    logic                done_in;
    logic [DATA_W+15:0]  write_bus;
    logic [ADDR_W-1:0]   write_addr;
    logic                write_en;
    logic [DATA_W-1:0]   cdf_total;
    logic                overflow;
    logic [DATA_W-1:0]   cdf_min;
    logic                done;

    int n_tests = 0;
    int n_fail  = 0;

    cdf_accumulate dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .acc_in        (acc_in),
        .start_in      (start_in),
        .store_addr_in (store_addr_in),
        .done_in       (done_in),
        .write_bus     (write_bus),
        .write_addr    (write_addr),
        .write_en      (write_en),
        .cdf_total     (cdf_total),
        .overflow      (overflow),
        .cdf_min       (cdf_min),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bin(input logic [DATA_W-1:0] v, input logic [ADDR_W-1:0] a, input logic last);
        start_in      = 1'b1;
        acc_in        = v;
        store_addr_in = a;
        done_in       = last;
        tick();
        start_in = 1'b0;
        done_in  = 1'b0;
    endtask

    function automatic logic [63:0] wb(input logic [DATA_W-1:0] v);
        return {28'd0, 16'hAAAA, v};
    endfunction

    initial begin
        int pulses;
        logic [DATA_W-1:0] exp_min;

        reset_n = 1'b0; start = 1'b0; acc_in = '0; start_in = 1'b0;
        store_addr_in = '0; done_in = 1'b0;
        #12;
        chk("rst_wen", write_en, 0);
        chk("rst_bus", write_bus, 0);
        chk("rst_done", done, 0);
        chk("rst_total", cdf_total, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Full pass of 256 ones.
        start = 1'b1;
        tick();
        for (int k = 1; k <= 256; k++) begin
            bin(20'd1, 16'(k - 1), k == 256);
            chk("p2_wen", write_en, 1);
            chk("p2_bus", write_bus, wb(20'(k)));
            chk("p2_addr", write_addr, 64'(k - 1));
        end
        chk("p2_done", done, 1);
        chk("p2_total", cdf_total, 256);
        chk("p2_ovf", overflow, 0);
        tick();
        chk("p2_wen_off", write_en, 0);
        chk("p2_done_hold", done, 1);
        start = 1'b0;
        tick();
        chk("p2_done_clr", done, 0);
        chk("p2_total_clr", cdf_total, 0);
        chk("p2_bus_clr", write_bus, 0);

        // Saturation.
        start = 1'b1;
        tick();
        bin(20'h80000, 16'd0, 1'b0);
        chk("p3_w1", write_bus, wb(20'h80000));
        chk("p3_ovf1", overflow, 0);
        bin(20'h80000, 16'd1, 1'b0);
        chk("p3_w2", write_bus, wb(20'hFFFFF));
        chk("p3_ovf2", overflow, 1);
        bin(20'h80000, 16'd2, 1'b0);
        chk("p3_w3", write_bus, wb(20'hFFFFF));
        tick();
        chk("p3_ovf_hold", overflow, 1);
        chk("p3_wen_idle", write_en, 0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("p3_total", cdf_total, 20'hFFFFF);
        chk("p3_ovf_done", overflow, 1);
        start = 1'b0;
        tick();
        chk("p3_ovf_clr", overflow, 0);

        // Bin limit: 260 pulses, only 256 written.
        start = 1'b1;
        tick();
        pulses = 0;
        for (int k = 1; k <= 260; k++) begin
            bin(20'(k), 16'(k), 1'b0);
            if (write_en) pulses++;
        end
        chk("p4_pulses", 64'(pulses), 256);
        chk("p4_bus_hold", write_bus, wb(20'd32896));
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("p4_total", cdf_total, 32896);
        start = 1'b0;
        tick();

        // Abort mid-pass then restart from zero.
        start = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) bin(20'd5, 16'(k), 1'b0);
        chk("p5_sum10", write_bus, wb(20'd50));
        start = 1'b0;
        tick();
        chk("p5_wen", write_en, 0);
        chk("p5_done", done, 0);
        start = 1'b1;
        tick();
        bin(20'd3, 16'd7, 1'b0);
        chk("p5_restart", write_bus, wb(20'd3));
        chk("p5_restart_addr", write_addr, 7);
        start = 1'b0;
        tick();

        // First-nonzero tracking.
`ifdef CDF_MIN_TRACK_EN
        exp_min = 20'd7;
`else
        exp_min = 20'd0;
`endif
        start = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) bin(20'd0, 16'(k), 1'b0);
        chk("p6_min_zero", cdf_min, 0);
        bin(20'd7, 16'd5, 1'b0);
        chk("p6_min_b5", cdf_min, exp_min);
        bin(20'd2, 16'd6, 1'b0);
        chk("p6_min_b6", cdf_min, exp_min);
        chk("p6_bus_b6", write_bus, wb(20'd9));
        start = 1'b0;
        tick();
        chk("p6_min_clr", cdf_min, 0);

        // Asynchronous reset while a write is on the bus.
        start = 1'b1;
        tick();
        bin(20'd11, 16'd4, 1'b0);
        chk("p1_pre_wen", write_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("p1_rst_wen", write_en, 0);
        chk("p1_rst_bus", write_bus, 0);
        chk("p1_rst_addr", write_addr, 0);
        start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("p1_post_wen", write_en, 0);
        chk("p1_post_bus", write_bus, 0);
        chk("p1_post_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
